// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multicycle core.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      EXEC1  = 2'b01,
      EXEC2  = 2'b10,
      HALTED = 2'b11
   } state_t;

   // Jump target that the decoder treats as a halt request.
   localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/mips_state_controller.sv
// Multicycle sequencer for the MIPS core: owns the CPU state, the memory
// request strobes, the datapath write enables and the retired-instruction count.
//
// state  | meaning
// FETCH  | instruction read; IR captured on the edge that leaves it
// EXEC1  | execute / optional data access; PC updated on exit
// EXEC2  | load writeback or second cycle of multicycle op
// HALTED | stopped until reset
module mips_state_controller
   import mips_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 waitrequest,
   input  logic                 needs_exec2,
   input  logic                 data_access,
   input  logic                 data_write,
   input  logic                 halt_req,
   output logic [1:0]           state,
   output logic                 ir_load,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 pc_write_en,
   output logic                 reg_write_en,
   output logic                 active,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic                   halt_pending_q, halt_pending_d;
   logic [CNT_WIDTH-1:0]   instr_count_q;
   logic                   retire;

   always_comb begin
      state_d        = state_q;
      halt_pending_d = halt_pending_q;
      retire         = 1'b0;
      ir_load        = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      pc_write_en    = 1'b0;
      reg_write_en   = 1'b0;

      case (state_q)
         FETCH: begin
            mem_read = 1'b1;
            if (!waitrequest) begin
               ir_load = 1'b1;
               state_d = EXEC1;
            end
         end
         EXEC1: begin
            mem_read  = data_access & ~data_write;
            mem_write = data_access & data_write;
            // waitrequest only stalls EXEC1 when a data access is in flight
            if (!(data_access && waitrequest)) begin
               pc_write_en    = 1'b1;
               reg_write_en   = ~needs_exec2;
               retire         = ~needs_exec2;
               halt_pending_d = halt_req;
               if (needs_exec2)
                  state_d = EXEC2;
               else if (halt_req)
                  state_d = HALTED;
               else
                  state_d = FETCH;
            end
         end
         EXEC2: begin
            reg_write_en   = 1'b1;
            retire         = 1'b1;
            halt_pending_d = 1'b0;
            state_d        = halt_pending_q ? HALTED : FETCH;
         end
         default: begin
            state_d = HALTED;
         end
      endcase

      // An access in progress when reset arrives is abandoned silently.
      if (!reset_n) begin
         ir_load      = 1'b0;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         pc_write_en  = 1'b0;
         reg_write_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= FETCH;
         halt_pending_q <= 1'b0;
         instr_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         halt_pending_q <= halt_pending_d;
         if (retire)
            instr_count_q <= instr_count_q + CNT_ONE;
      end
   end

   assign state       = state_q;
   assign active      = (state_q != HALTED);
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_state_controller.sv
// Directed bench for mips_state_controller with a 4-bit retired-instruction counter.
module tb_mips_state_controller;

   logic       clk;
   logic       reset_n;
   logic       waitrequest;
   logic       needs_exec2;
   logic       data_access;
   logic       data_write;
   logic       halt_req;
   logic [1:0] state;
   logic       ir_load;
   logic       mem_read;
   logic       mem_write;
   logic       pc_write_en;
   logic       reg_write_en;
   logic       active;
   logic [3:0] instr_count;

   int total = 0;
   int bad   = 0;

   mips_state_controller #(.CNT_WIDTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .waitrequest  (waitrequest),
      .needs_exec2  (needs_exec2),
      .data_access  (data_access),
      .data_write   (data_write),
      .halt_req     (halt_req),
      .state        (state),
      .ir_load      (ir_load),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .pc_write_en  (pc_write_en),
      .reg_write_en (reg_write_en),
      .active       (active),
      .instr_count  (instr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic w, input logic ne, input logic da,
                         input logic dw, input logic h);
      waitrequest = w;
      needs_exec2 = ne;
      data_access = da;
      data_write  = dw;
      halt_req    = h;
   endtask

   // Outputs packed as {ir_load, mem_read, mem_write, pc_write_en, reg_write_en, active}.
   task automatic cyc(input string tag, input logic [1:0] es, input logic [5:0] eo);
      @(negedge clk);
      check({tag, "_st"}, {30'b0, state}, {30'b0, es});
      check({tag, "_out"},
            {26'b0, ir_load, mem_read, mem_write, pc_write_en, reg_write_en, active},
            {26'b0, eo});
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag, input logic [3:0] exp);
      check(tag, {28'b0, instr_count}, {28'b0, exp});
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      cyc("rst", 2'b00, 6'b000001);
      check_cnt("rst_cnt", 4'd0);
      reset_n = 1'b1;

      // ALU op, no waits
      cyc("alu_f", 2'b00, 6'b110001);
      cyc("alu_e1", 2'b01, 6'b000111);
      check_cnt("alu_cnt", 4'd1);

      // load with three EXEC1 wait cycles
      cyc("ld_f", 2'b00, 6'b110001);
      set_in(1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc("ld_wait", 2'b01, 6'b010001);
      set_in(0, 1, 1, 0, 0);
      cyc("ld_e1", 2'b01, 6'b010101);
      set_in(0, 0, 0, 0, 0);
      cyc("ld_e2", 2'b10, 6'b000011);
      check_cnt("ld_cnt", 4'd2);

      // fetch stalled two cycles; EXEC1 ignores waitrequest without a data access
      set_in(1, 0, 0, 0, 0);
      cyc("fw_0", 2'b00, 6'b010001);
      cyc("fw_1", 2'b00, 6'b010001);
      set_in(0, 0, 0, 0, 0);
      cyc("fw_f", 2'b00, 6'b110001);
      set_in(1, 0, 0, 0, 0);
      cyc("fw_e1", 2'b01, 6'b000111);
      check_cnt("fw_cnt", 4'd3);

      // halt on a single-cycle instruction
      set_in(0, 0, 0, 0, 0);
      cyc("h1_f", 2'b00, 6'b110001);
      set_in(0, 0, 0, 0, 1);
      cyc("h1_e1", 2'b01, 6'b000111);
      check_cnt("h1_cnt", 4'd4);
      set_in(0, 1, 1, 1, 1);
      cyc("h1_hlt0", 2'b11, 6'b000000);
      set_in(1, 0, 1, 0, 0);
      cyc("h1_hlt1", 2'b11, 6'b000000);
      check_cnt("h1_frz", 4'd4);
      reset_n = 1'b0;
      cyc("h1_rst", 2'b11, 6'b000000);
      reset_n = 1'b1;
      set_in(0, 0, 0, 0, 0);
      check_cnt("h1_rcnt", 4'd0);

      // halt with EXEC2
      cyc("h2_f", 2'b00, 6'b110001);
      set_in(0, 1, 1, 0, 1);
      cyc("h2_e1", 2'b01, 6'b010101);
      set_in(0, 0, 0, 0, 0);
      cyc("h2_e2", 2'b10, 6'b000011);
      cyc("h2_hlt", 2'b11, 6'b000000);
      check_cnt("h2_cnt", 4'd1);
      reset_n = 1'b0;
      cyc("h2_rst", 2'b11, 6'b000000);
      reset_n = 1'b1;

      // reset during a fetch stall
      set_in(1, 0, 0, 0, 0);
      cyc("rs_f", 2'b00, 6'b010001);
      reset_n = 1'b0;
      cyc("rs_rst", 2'b00, 6'b000001);
      reset_n = 1'b1;
      set_in(0, 0, 0, 0, 0);

      // reset during EXEC2
      cyc("re_f", 2'b00, 6'b110001);
      set_in(0, 1, 1, 0, 0);
      cyc("re_e1", 2'b01, 6'b010101);
      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0);
      cyc("re_rst", 2'b10, 6'b000001);
      reset_n = 1'b1;
      check_cnt("re_cnt", 4'd0);

      // store with one wait cycle
      cyc("st_f", 2'b00, 6'b110001);
      set_in(1, 0, 1, 1, 0);
      cyc("st_wait", 2'b01, 6'b001001);
      set_in(0, 0, 1, 1, 0);
      cyc("st_e1", 2'b01, 6'b001111);
      set_in(0, 0, 0, 0, 0);
      check_cnt("st_cnt", 4'd1);
      reset_n = 1'b0;
      cyc("st_rst", 2'b00, 6'b000001);
      reset_n = 1'b1;

      // counter wrap: 17 retirements on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         cyc("wr_f", 2'b00, 6'b110001);
         cyc("wr_e1", 2'b01, 6'b000111);
         if (i == 14) check_cnt("wr_15", 4'd15);
         if (i == 15) check_cnt("wr_0", 4'd0);
      end
      check_cnt("wr_1", 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
